cond_exmem: RTL and testbench

Execute-stage condition unit and EX/MEM pipeline register, directly downstream of the ALU. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit ARM condition field against the stored flags. It gates the register-write, memory-write, branch and flag-write controls by that condition, and registers the ALU result and controls into the Memory stage. Stall and flush inputs come from the hazard unit.

---
 rtl/cond_exmem_if.sv | 59 +++++
 rtl/cond_exmem.sv | 101 ++++++++++
 tb/tb_cond_exmem.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_exmem_if.sv
// cond_exmem_if
//   Groups the Execute-side inputs and Memory-side outputs of the
//   condition unit / EX/MEM pipeline register into one bundle.
//   Width parameter n is the datapath width.
//   master : upstream side (drives Execute values, hazard controls; observes results)
//   slave  : cond_exmem itself
//   Signals:
//     EnE, FlushE                 stage enable / bubble insert
//     CondE, FlagWE               condition field, flag-write enables {NZ, CV}
//     PCSrcE, RegWE, MemWE,
//     MemtoRegE                   ungated decode controls
//     ALUFlags                    {N,Z,C,V} from the ALU
//     ALUResultE, WriteDataE,
//     WA3E                        Execute data and destination register
//     Flags                       registered {N,Z,C,V}
//     CondExE, PCSrcTakenE        combinational condition result / taken branch
//     RegWriteM, MemWriteM,
//     MemtoRegM, ALUResultM,
//     WriteDataM, WA3M            registered Memory-stage values
interface cond_exmem_if #(
   parameter int unsigned n = 32
);
   logic          EnE;
   logic          FlushE;
   logic [3:0]    CondE;
   logic [1:0]    FlagWE;
   logic          PCSrcE;
   logic          RegWE;
   logic          MemWE;
   logic          MemtoRegE;
   logic [3:0]    ALUFlags;
   logic [n-1:0]  ALUResultE;
   logic [n-1:0]  WriteDataE;
   logic [3:0]    WA3E;

   logic [3:0]    Flags;
   logic          CondExE;
   logic          PCSrcTakenE;
   logic          RegWriteM;
   logic          MemWriteM;
   logic          MemtoRegM;
   logic [n-1:0]  ALUResultM;
   logic [n-1:0]  WriteDataM;
   logic [3:0]    WA3M;

   modport master (
      output EnE, FlushE, CondE, FlagWE, PCSrcE, RegWE, MemWE, MemtoRegE,
             ALUFlags, ALUResultE, WriteDataE, WA3E,
      input  Flags, CondExE, PCSrcTakenE, RegWriteM, MemWriteM, MemtoRegM,
             ALUResultM, WriteDataM, WA3M
   );

   modport slave (
      input  EnE, FlushE, CondE, FlagWE, PCSrcE, RegWE, MemWE, MemtoRegE,
             ALUFlags, ALUResultE, WriteDataE, WA3E,
      output Flags, CondExE, PCSrcTakenE, RegWriteM, MemWriteM, MemtoRegM,
             ALUResultM, WriteDataM, WA3M
   );
endinterface

// File: rtl/cond_exmem.sv
// cond_exmem
//   Execute-stage condition unit plus EX/MEM pipeline register.
//   Holds the NZCV flag register, evaluates the ARM condition field against
//   it, gates register/memory/flag writes and branch by the result, and
//   registers ALU result and controls into the Memory stage.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears flags and EX/MEM register
//     bus    cond_exmem_if.slave (see interface for signal list)
module cond_exmem #(
   parameter int unsigned n = 32
) (
   input  logic         clk,
   input  logic         reset,
   cond_exmem_if.slave  bus
);

   logic [3:0]    flags_q, flags_d;
   logic          reg_write_q, mem_write_q, memtoreg_q;
   logic [n-1:0]  alu_result_q, write_data_q;
   logic [3:0]    wa3_q;

   logic          cond_ex;
   logic [1:0]    flag_w;
   logic          fN, fZ, fC, fV;

   assign {fN, fZ, fC, fV} = flags_q;

   // Condition is always judged against flags from before the current edge.
   always_comb begin
      cond_ex = 1'b0;
      unique case (bus.CondE)
         4'b0000: cond_ex = fZ;
         4'b0001: cond_ex = ~fZ;
         4'b0010: cond_ex = fC;
         4'b0011: cond_ex = ~fC;
         4'b0100: cond_ex = fN;
         4'b0101: cond_ex = ~fN;
         4'b0110: cond_ex = fV;
         4'b0111: cond_ex = ~fV;
         4'b1000: cond_ex = fC & ~fZ;
         4'b1001: cond_ex = ~fC | fZ;
         4'b1010: cond_ex = (fN == fV);
         4'b1011: cond_ex = (fN != fV);
         4'b1100: cond_ex = ~fZ & (fN == fV);
         4'b1101: cond_ex = fZ | (fN != fV);
         4'b1110: cond_ex = 1'b1;
         4'b1111: cond_ex = 1'b0;
      endcase
   end

   assign flag_w = bus.FlagWE & {2{cond_ex}};

   // N,Z and C,V halves are written independently.
   always_comb begin
      flags_d = flags_q;
      if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
   end

   // Priority: reset > stall > flush > normal. A flush also blocks flag writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q      <= '0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         memtoreg_q   <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         wa3_q        <= '0;
      end else if (bus.EnE) begin
         if (bus.FlushE) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            memtoreg_q   <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            wa3_q        <= '0;
         end else begin
            flags_q      <= flags_d;
            reg_write_q  <= bus.RegWE & cond_ex;
            mem_write_q  <= bus.MemWE & cond_ex;
            memtoreg_q   <= bus.MemtoRegE;
            alu_result_q <= bus.ALUResultE;
            write_data_q <= bus.WriteDataE;
            wa3_q        <= bus.WA3E;
         end
      end
   end

   assign bus.Flags       = flags_q;
   assign bus.CondExE     = cond_ex;
   assign bus.PCSrcTakenE = bus.PCSrcE & cond_ex;
   assign bus.RegWriteM   = reg_write_q;
   assign bus.MemWriteM   = mem_write_q;
   assign bus.MemtoRegM   = memtoreg_q;
   assign bus.ALUResultM  = alu_result_q;
   assign bus.WriteDataM  = write_data_q;
   assign bus.WA3M        = wa3_q;

endmodule

// File: tb/tb_cond_exmem.sv
module tb_cond_exmem;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   cond_exmem_if #(.n(32)) bus ();

   cond_exmem #(.n(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ctrl(input logic [3:0] cond, input logic [1:0] fwe,
                           input logic [3:0] aflags);
      bus.CondE    = cond;
      bus.FlagWE   = fwe;
      bus.ALUFlags = aflags;
   endtask

   task automatic edge_then_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_point();
      @(negedge clk);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset          = 1'b1;
      bus.EnE        = 1'b1;
      bus.FlushE     = 1'b0;
      bus.CondE      = 4'b1110;
      bus.FlagWE     = 2'b00;
      bus.PCSrcE     = 1'b0;
      bus.RegWE      = 1'b0;
      bus.MemWE      = 1'b0;
      bus.MemtoRegE  = 1'b0;
      bus.ALUFlags   = 4'b0000;
      bus.ALUResultE = 32'h0;
      bus.WriteDataE = 32'h0;
      bus.WA3E       = 4'h0;
      repeat (2) @(posedge clk);
      drive_point();
      reset = 1'b0;

      // Reset state
      #1;
      check("rst_flags", 32'(bus.Flags), 32'h0);
      check("rst_regwm", 32'(bus.RegWriteM), 32'h0);
      check("rst_aluresm", bus.ALUResultM, 32'h0);
      bus.CondE = 4'b0000; #1;
      check("rst_eq", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b0001; #1;
      check("rst_ne", 32'(bus.CondExE), 32'h1);

      // Flag set (AL) then EQ
      drive_point();
      set_ctrl(4'b1110, 2'b11, 4'b0100);
      edge_then_sample();
      check("fset_flags", 32'(bus.Flags), 32'h4);
      drive_point();
      set_ctrl(4'b0000, 2'b00, 4'b0000);
      bus.RegWE = 1'b1; bus.WA3E = 4'd5; bus.ALUResultE = 32'h1234; bus.WriteDataE = 32'hBEEF;
      #1;
      check("eq_pass", 32'(bus.CondExE), 32'h1);
      edge_then_sample();
      check("eq_regwm", 32'(bus.RegWriteM), 32'h1);
      check("eq_wa3m", 32'(bus.WA3M), 32'h5);
      check("eq_aluresm", bus.ALUResultM, 32'h1234);
      check("eq_wdatam", bus.WriteDataM, 32'hBEEF);

      // Partial flag write: CV only
      drive_point();
      bus.RegWE = 1'b0;
      set_ctrl(4'b1110, 2'b11, 4'b1000);
      edge_then_sample();
      check("part_pre", 32'(bus.Flags), 32'h8);
      drive_point();
      set_ctrl(4'b1110, 2'b01, 4'b0111);
      edge_then_sample();
      check("part_cv", 32'(bus.Flags), 32'hB);

      // Signed conditions, Flags=1001
      drive_point();
      set_ctrl(4'b1110, 2'b11, 4'b1001);
      edge_then_sample();
      drive_point();
      set_ctrl(4'b1100, 2'b00, 4'b0000); #1;
      check("f1001_gt", 32'(bus.CondExE), 32'h1);
      bus.CondE = 4'b1101; #1;
      check("f1001_le", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b1010; #1;
      check("f1001_ge", 32'(bus.CondExE), 32'h1);

      // Flags=1000
      set_ctrl(4'b1110, 2'b11, 4'b1000);
      edge_then_sample();
      drive_point();
      set_ctrl(4'b1100, 2'b00, 4'b0000); #1;
      check("f1000_gt", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b1011; #1;
      check("f1000_lt", 32'(bus.CondExE), 32'h1);
      bus.CondE = 4'b0100; #1;
      check("f1000_mi", 32'(bus.CondExE), 32'h1);

      // Flags=0100
      set_ctrl(4'b1110, 2'b11, 4'b0100);
      edge_then_sample();
      drive_point();
      set_ctrl(4'b1100, 2'b00, 4'b0000); #1;
      check("f0100_gt", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b1101; #1;
      check("f0100_le", 32'(bus.CondExE), 32'h1);
      bus.CondE = 4'b1000; #1;
      check("f0100_hi", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b1001; #1;
      check("f0100_ls", 32'(bus.CondExE), 32'h1);
      bus.CondE = 4'b1111; #1;
      check("f0100_nv", 32'(bus.CondExE), 32'h0);

      // Flags=0011: carry and overflow conditions
      set_ctrl(4'b1110, 2'b11, 4'b0011);
      edge_then_sample();
      drive_point();
      set_ctrl(4'b1000, 2'b00, 4'b0000); #1;
      check("f0011_hi", 32'(bus.CondExE), 32'h1);
      bus.CondE = 4'b0111; #1;
      check("f0011_vc", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b0010; #1;
      check("f0011_cs", 32'(bus.CondExE), 32'h1);

      // Failed condition suppresses side effects; clear flags first
      set_ctrl(4'b1110, 2'b11, 4'b0000);
      edge_then_sample();
      check("fail_pre", 32'(bus.Flags), 32'h0);
      drive_point();
      set_ctrl(4'b0000, 2'b11, 4'b1111);
      bus.RegWE = 1'b1; bus.MemWE = 1'b1; bus.PCSrcE = 1'b1; bus.MemtoRegE = 1'b1;
      bus.ALUResultE = 32'hCAFE0001; bus.WA3E = 4'd9;
      #1;
      check("fail_cond", 32'(bus.CondExE), 32'h0);
      check("fail_taken", 32'(bus.PCSrcTakenE), 32'h0);
      edge_then_sample();
      check("fail_regwm", 32'(bus.RegWriteM), 32'h0);
      check("fail_memwm", 32'(bus.MemWriteM), 32'h0);
      check("fail_flags", 32'(bus.Flags), 32'h0);
      check("fail_m2r", 32'(bus.MemtoRegM), 32'h1);
      check("fail_aluresm", bus.ALUResultM, 32'hCAFE0001);

      // Branch taken under AL
      drive_point();
      set_ctrl(4'b1110, 2'b00, 4'b0000);
      bus.MemtoRegE = 1'b0;
      #1;
      check("al_taken", 32'(bus.PCSrcTakenE), 32'h1);

      // Load known M state for stall/flush checks
      bus.PCSrcE = 1'b0; bus.WA3E = 4'd7; bus.ALUResultE = 32'hAAAA;
      edge_then_sample();
      check("ld_regwm", 32'(bus.RegWriteM), 32'h1);
      check("ld_memwm", 32'(bus.MemWriteM), 32'h1);

      // Stall with new inputs
      drive_point();
      bus.EnE = 1'b0;
      set_ctrl(4'b1110, 2'b11, 4'b1111);
      bus.RegWE = 1'b0; bus.MemWE = 1'b0; bus.WA3E = 4'd3; bus.ALUResultE = 32'h5555;
      edge_then_sample();
      check("stall_regwm", 32'(bus.RegWriteM), 32'h1);
      check("stall_wa3m", 32'(bus.WA3M), 32'h7);
      check("stall_aluresm", bus.ALUResultM, 32'hAAAA);
      check("stall_flags", 32'(bus.Flags), 32'h0);

      // Stall with flush: still hold
      drive_point();
      bus.FlushE = 1'b1;
      edge_then_sample();
      check("stfl_memwm", 32'(bus.MemWriteM), 32'h1);
      check("stfl_aluresm", bus.ALUResultM, 32'hAAAA);
      check("stfl_flags", 32'(bus.Flags), 32'h0);

      // Flush with flag-setter: bubble, flags untouched
      drive_point();
      bus.EnE = 1'b1; bus.RegWE = 1'b1; bus.MemWE = 1'b1; bus.MemtoRegE = 1'b1;
      edge_then_sample();
      check("flush_regwm", 32'(bus.RegWriteM), 32'h0);
      check("flush_memwm", 32'(bus.MemWriteM), 32'h0);
      check("flush_m2r", 32'(bus.MemtoRegM), 32'h0);
      check("flush_aluresm", bus.ALUResultM, 32'h0);
      check("flush_wa3m", 32'(bus.WA3M), 32'h0);
      check("flush_flags", 32'(bus.Flags), 32'h0);

      // Build nonzero state, then reset mid-cycle during a stall
      drive_point();
      bus.FlushE = 1'b0; bus.MemtoRegE = 1'b0;
      bus.WA3E = 4'd12; bus.ALUResultE = 32'h0F0F0F0F;
      edge_then_sample();
      check("pre_rst_flags", 32'(bus.Flags), 32'hF);
      check("pre_rst_regwm", 32'(bus.RegWriteM), 32'h1);
      drive_point();
      bus.EnE = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_flags", 32'(bus.Flags), 32'h0);
      check("arst_regwm", 32'(bus.RegWriteM), 32'h0);
      check("arst_memwm", 32'(bus.MemWriteM), 32'h0);
      check("arst_aluresm", bus.ALUResultM, 32'h0);
      bus.CondE = 4'b0000; #1;
      check("arst_eq", 32'(bus.CondExE), 32'h0);
      bus.CondE = 4'b1100; #1;
      check("arst_gt", 32'(bus.CondExE), 32'h1);
      drive_point();
      reset = 1'b0;
      bus.EnE = 1'b1;
      edge_then_sample();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
